vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter: WFIFO_DEPTH, 4, CPU write-buffer entries (power of two, 2..16).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  enable  in  1  global enable.
  cpu_wr_valid  in  1  CPU framebuffer write request.
  cpu_wr_ready  out  1  request accepted when valid&&ready.
  cpu_wr_addr  in  15  word address.
  cpu_wr_data  in  16  write data.
  disp_rd  in  1  display read request this cycle.
  vgad_addr  in  15  display read address.
  vgad_data  out  16  display read data.
  disp_rd_valid  out  1  vgad_data updated this cycle.
  mem_addr  out  15  video RAM address.
  mem_wdata  out  16  video RAM write data.
  mem_we  out  1  video RAM write strobe.
  mem_rdata  in  16  video RAM read data, 1-cycle synchronous latency.

Function
REQ-003 SHALL buffer accepted CPU writes in a WFIFO_DEPTH-entry FIFO, retired strictly in acceptance order.
REQ-004 SHALL drive cpu_wr_ready = enable && (count != WFIFO_DEPTH), combinationally from registered count; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-005 SHALL grant the memory port each cycle by fixed priority: disp_rd first, then FIFO head if non-empty and enable high, else idle.
REQ-006 Display grant SHALL drive mem_addr=vgad_addr, mem_we=0 in the same cycle.
REQ-007 Write grant SHALL drive mem_addr/mem_wdata from FIFO head, mem_we=1, and pop the head at that clock edge.
REQ-008 Idle cycles SHALL drive mem_we=0, mem_addr=0, mem_wdata=0.
REQ-009 disp_rd in cycle N SHALL give disp_rd_valid=1 and vgad_data=read result in cycle N+1 (latency 1).
REQ-010 vgad_data SHALL hold the last read result in cycles with disp_rd_valid=0.
REQ-011 Simultaneous push and pop SHALL leave count unchanged and keep both entries correct.
REQ-012 Consecutive writes to one address SHALL both reach memory, in order.
REQ-013 enable=0 SHALL block push and write retirement, keep FIFO contents, and still serve display reads.
REQ-014 Continuous disp_rd SHALL stall writes indefinitely without loss; no timeout.
REQ-015 count SHALL be a clog2(WFIFO_DEPTH)+1-bit counter; pointers SHALL wrap modulo WFIFO_DEPTH.

Reset
REQ-016 reset low SHALL immediately clear FIFO (count=0, pointers=0), vgad_data=0, disp_rd_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_wr_ready=0.
REQ-017 Reset mid-operation SHALL discard buffered writes and any in-flight read result.
REQ-018 First cycle after release SHALL show cpu_wr_ready=enable.

Configuration
REQ-019 Macro VGA_FB_RAW_BYPASS_EN defined: a display read in cycle N whose vgad_addr matches a buffered FIFO entry SHALL return the youngest match's data in N+1 instead of mem_rdata; match set is captured in cycle N.
REQ-020 Macro undefined: display reads SHALL always return mem_rdata (buffered writes invisible until retired); no compare logic present.

Structure
REQ-021 Package vga_fb_pkg SHALL hold VGA_ADDR_W=15, VGA_DATA_W=16 and the FIFO entry type {addr, data}.
REQ-022 FIFO SHALL be sub-module vga_fb_wfifo (push/pop/full/empty/head, plus entry visibility under VGA_FB_RAW_BYPASS_EN); arbitration and read return stay in the top.

Verification
REQ-023 Bench SHALL cover:
  Idle, push {0x0010,0xBEEF}, disp_rd=0 -> next cycle mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF, FIFO empty.
  disp_rd=1 held 6 cycles, 5 CPU pushes, depth 4 -> ready=0 after 4th, 5th held; no mem_we until disp_rd drops, then 4 writes in order.
  disp_rd, vgad_addr=0x1234, mem_rdata=0x00A5 next cycle -> disp_rd_valid=1, vgad_data=0x00A5, held afterwards.
  Full FIFO, valid=1, write retires -> no push that cycle; push next cycle, count back to 4.
  Bypass on: buffered {0x0020,0x1111},{0x0020,0x2222}, disp_rd 0x0020 -> vgad_data=0x2222; bypass off -> mem_rdata.
  reset low with 3 entries and read in flight -> all outputs 0 at once; after release no mem_we, ready=1 with enable=1.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared widths and the write-buffer entry type for the VGA framebuffer arbiter.
package vga_fb_pkg;

   localparam int VGA_ADDR_W = 15;
   localparam int VGA_DATA_W = 16;

   // One buffered CPU write: target word address plus data.
   typedef struct packed {
      logic [VGA_ADDR_W-1:0] addr;
      logic [VGA_DATA_W-1:0] data;
   } wfifo_entry_t;

endpackage

// File: rtl/vga_fb_wfifo.sv
// CPU write buffer for the VGA framebuffer arbiter.
// Circular buffer of DEPTH entries (power of two) with a clog2(DEPTH)+1 bit
// occupancy counter. With VGA_FB_RAW_BYPASS_EN defined, every entry is also
// exported in age order (index 0 = oldest) with a valid mask so the top can
// forward buffered data to display reads.
module vga_fb_wfifo
   import vga_fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_push,
   input  wfifo_entry_t            i_push_entry,
   input  logic                    i_pop,
   output logic                    o_full,
   output logic                    o_empty,
`ifdef VGA_FB_RAW_BYPASS_EN
   output wfifo_entry_t [DEPTH-1:0] o_entries,
   output logic [DEPTH-1:0]        o_entry_valid,
`endif
   output wfifo_entry_t            o_head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wfifo_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   // Entry storage; not reset, the counter alone defines which slots are live.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_entry;
      end
   end

   // Pointers wrap naturally at DEPTH; a simultaneous push and pop keeps count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

`ifdef VGA_FB_RAW_BYPASS_EN
   // Age-ordered view of the buffer: slot gi is the gi-th oldest live entry.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
      logic [PTR_W-1:0] w_idx;
      assign w_idx             = r_rd_ptr + PTR_W'(gi);
      assign o_entries[gi]     = r_mem[w_idx];
      assign o_entry_valid[gi] = (CNT_W'(gi) < r_count);
   end
`endif

endmodule

// File: rtl/vga_fb_arbiter.sv
// VGA framebuffer memory-port arbiter.
// Display reads always win the single video RAM port; buffered CPU writes
// retire in order whenever the port is free and enable is high. Read data
// comes back one cycle after the request and is held between reads.
// Optional feature macro: VGA_FB_RAW_BYPASS_EN (display reads see the
// youngest buffered write to the same address).
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  cpu_wr_valid,
   output logic                  cpu_wr_ready,
   input  logic [VGA_ADDR_W-1:0] cpu_wr_addr,
   input  logic [VGA_DATA_W-1:0] cpu_wr_data,
   input  logic                  disp_rd,
   input  logic [VGA_ADDR_W-1:0] vgad_addr,
   output logic [VGA_DATA_W-1:0] vgad_data,
   output logic                  disp_rd_valid,
   output logic [VGA_ADDR_W-1:0] mem_addr,
   output logic [VGA_DATA_W-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [VGA_DATA_W-1:0] mem_rdata
);

   logic         w_full;
   logic         w_empty;
   logic         w_push;
   logic         w_grant_rd;
   logic         w_grant_wr;
   wfifo_entry_t w_head;
   wfifo_entry_t w_push_entry;
   logic [VGA_DATA_W-1:0] w_rd_result;

   logic                  r_rd_valid;
   logic [VGA_DATA_W-1:0] r_rd_hold;

   // Readiness comes only from the registered count, so a pop in the same
   // cycle never opens a full buffer. Reset forces it low immediately.
   assign cpu_wr_ready = reset & enable & ~w_full;
   assign w_push       = cpu_wr_valid & cpu_wr_ready;
   assign w_push_entry = '{addr: cpu_wr_addr, data: cpu_wr_data};

   // Fixed priority: display read, then buffered write, else idle.
   assign w_grant_rd = reset & disp_rd;
   assign w_grant_wr = reset & ~disp_rd & ~w_empty & enable;

`ifdef VGA_FB_RAW_BYPASS_EN
   wfifo_entry_t [WFIFO_DEPTH-1:0] w_entries;
   logic [WFIFO_DEPTH-1:0]         w_entry_valid;
   logic                           w_byp_hit;
   logic [VGA_DATA_W-1:0]          w_byp_data;
   logic                           r_byp_hit;
   logic [VGA_DATA_W-1:0]          r_byp_data;
`endif

   vga_fb_wfifo #(
      .DEPTH         (WFIFO_DEPTH)
   ) u_wfifo (
      .clk           (clk),
      .reset         (reset),
      .i_push        (w_push),
      .i_push_entry  (w_push_entry),
      .i_pop         (w_grant_wr),
      .o_full        (w_full),
      .o_empty       (w_empty),
`ifdef VGA_FB_RAW_BYPASS_EN
      .o_entries     (w_entries),
      .o_entry_valid (w_entry_valid),
`endif
      .o_head        (w_head)
   );

   // Memory port mux; idle cycles drive all zeros.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_grant_rd) begin
         mem_addr = vgad_addr;
      end else if (w_grant_wr) begin
         mem_we    = 1'b1;
         mem_addr  = w_head.addr;
         mem_wdata = w_head.data;
      end
   end

`ifdef VGA_FB_RAW_BYPASS_EN
   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      w_byp_hit  = 1'b0;
      w_byp_data = '0;
      for (int k = 0; k < WFIFO_DEPTH; k++) begin
         if (w_entry_valid[k] && (w_entries[k].addr == vgad_addr)) begin
            w_byp_hit  = 1'b1;
            w_byp_data = w_entries[k].data;
         end
      end
   end

   // Capture the match alongside the read request so it lines up with mem_rdata.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_byp_hit  <= 1'b0;
         r_byp_data <= '0;
      end else begin
         r_byp_hit  <= w_grant_rd & w_byp_hit;
         r_byp_data <= w_byp_data;
      end
   end

   assign w_rd_result = r_byp_hit ? r_byp_data : mem_rdata;
`else
   assign w_rd_result = mem_rdata;
`endif

   // Fresh result in the cycle after a read grant, otherwise the held value.
   assign disp_rd_valid = r_rd_valid;
   assign vgad_data     = r_rd_valid ? w_rd_result : r_rd_hold;

   // Read-return tracking: flags the returning cycle and remembers the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_valid <= 1'b0;
         r_rd_hold  <= '0;
      end else begin
         r_rd_valid <= w_grant_rd;
         r_rd_hold  <= vgad_data;
      end
   end

endmodule
